// File: rtl/mod7_seq_checker.sv
// Sequence checker for a mod-MOD counter: locks onto a 0..MOD-1 incrementing
// stream, then counts wraps and sequence errors and flags illegal codes.
module mod7_seq_checker #(
  parameter int unsigned MOD      = 7,
  parameter int unsigned CYC_W    = 8,
  parameter int unsigned ERR_W    = 4,
  parameter int unsigned SYNC_LEN = 2
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             start,
  input  logic             sample,
  input  logic [2:0]       cnt,
  output logic [1:0]       state,
  output logic             locked,
  output logic             err_pulse,
  output logic             illegal,
  output logic             err_sticky,
  output logic [CYC_W-1:0] wraps,
  output logic [ERR_W-1:0] errs
);

  localparam int unsigned RUN_W = (SYNC_LEN < 1) ? 1 : $clog2(SYNC_LEN + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SYNC  = 2'b01,
    LOCK  = 2'b10,
    FAULT = 2'b11
  } state_t;

  state_t           st;
  logic [2:0]       prev;
  logic [RUN_W-1:0] run;
  logic             first;
  logic [3:0]       exp4;
  logic             match;
  logic             bad;
  logic [RUN_W-1:0] run_inc;

  // Expected value uses 4-bit math so 7+1 reduces to 1 rather than wrapping to 0.
  always_comb begin
    exp4    = ({1'b0, prev} + 4'd1) % 4'(MOD);
    match   = ({1'b0, cnt} == exp4);
    bad     = ({1'b0, cnt} >= 4'(MOD));
    run_inc = run + RUN_W'(1);
  end

  assign state = st;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      st         <= IDLE;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      illegal    <= 1'b0;
      err_sticky <= 1'b0;
      wraps      <= '0;
      errs       <= '0;
      prev       <= '0;
      run        <= '0;
      first      <= 1'b0;
    end else begin
      err_pulse <= 1'b0;
      illegal   <= 1'b0;
      if (start) begin
        st         <= SYNC;
        locked     <= 1'b0;
        wraps      <= '0;
        errs       <= '0;
        err_sticky <= 1'b0;
        prev       <= '0;
        run        <= '0;
        first      <= 1'b1;
      end else if (sample && st != IDLE) begin
        illegal <= bad;
        prev    <= cnt;
        case (st)
          SYNC: begin
            if (first) begin
              run   <= '0;
              first <= 1'b0;
            end else if (match) begin
              if (run_inc == RUN_W'(SYNC_LEN)) begin
                st     <= LOCK;
                locked <= 1'b1;
                run    <= '0;
              end else begin
                run <= run_inc;
              end
            end else begin
              run <= '0;
            end
          end
          LOCK: begin
            if (match) begin
              if (prev == 3'(MOD - 1) && cnt == '0 && wraps != '1)
                wraps <= wraps + CYC_W'(1);
            end else begin
              err_pulse  <= 1'b1;
              err_sticky <= 1'b1;
              if (errs != '1)
                errs <= errs + ERR_W'(1);
              st     <= FAULT;
              locked <= 1'b0;
            end
          end
          FAULT: begin
            // This sample acts as the first SYNC sample, so no reload is pending.
            run   <= '0;
            first <= 1'b0;
            st    <= SYNC;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mod7_seq_checker.sv
// Scoreboard bench for mod7_seq_checker: a history-window reference model
// predicts every cycle's outputs; a monitor pops and compares them.
module tb_mod7_seq_checker;

  localparam int MOD      = 7;
  localparam int CYC_W    = 8;
  localparam int ERR_W    = 4;
  localparam int SYNC_LEN = 2;
  localparam int WR_MAX   = (1 << CYC_W) - 1;
  localparam int ER_MAX   = (1 << ERR_W) - 1;

  logic             clk = 1'b0;
  logic             clr;
  logic             start;
  logic             sample;
  logic [2:0]       cnt;
  logic [1:0]       state;
  logic             locked;
  logic             err_pulse;
  logic             illegal;
  logic             err_sticky;
  logic [CYC_W-1:0] wraps;
  logic [ERR_W-1:0] errs;

  mod7_seq_checker #(
    .MOD(MOD), .CYC_W(CYC_W), .ERR_W(ERR_W), .SYNC_LEN(SYNC_LEN)
  ) dut (
    .clk(clk), .clr(clr), .start(start), .sample(sample), .cnt(cnt),
    .state(state), .locked(locked), .err_pulse(err_pulse), .illegal(illegal),
    .err_sticky(err_sticky), .wraps(wraps), .errs(errs)
  );

  always #5 clk = ~clk;

  typedef struct {
    int st; int lk; int ep; int il; int sk; int wr; int er;
  } exp_t;

  exp_t q[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  // Reference model: mode 0=IDLE 1=SYNC 2=LOCK 3=FAULT
  int m_mode, m_prev, m_wraps, m_errs, m_sticky, m_ep, m_il;
  int m_hist[$];

  task automatic chk(input string name, input int act, input int want);
    n_chk++;
    if (act != want) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask

  function automatic bit window_ok();
    if (m_hist.size() < SYNC_LEN + 1) return 1'b0;
    for (int i = m_hist.size() - SYNC_LEN; i < m_hist.size(); i++)
      if (m_hist[i] != (m_hist[i-1] + 1) % MOD) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_prev = 0; m_wraps = 0; m_errs = 0; m_sticky = 0;
    m_ep = 0; m_il = 0;
    m_hist.delete();
  endtask

  task automatic model(input bit s, input bit smp, input int c);
    m_ep = 0;
    m_il = 0;
    if (s) begin
      m_mode = 1; m_wraps = 0; m_errs = 0; m_sticky = 0;
      m_hist.delete();
    end else if (smp && m_mode != 0) begin
      m_il = (c >= MOD);
      case (m_mode)
        1: begin
          m_hist.push_back(c);
          if (window_ok()) begin
            m_mode = 2;
            m_prev = c;
          end
        end
        2: begin
          if (c == (m_prev + 1) % MOD) begin
            if (m_prev == MOD - 1 && m_wraps < WR_MAX) m_wraps++;
            m_prev = c;
          end else begin
            m_ep = 1; m_sticky = 1; m_mode = 3;
            if (m_errs < ER_MAX) m_errs++;
          end
        end
        default: begin
          m_hist.delete();
          m_hist.push_back(c);
          m_mode = 1;
        end
      endcase
    end
  endtask

  task automatic step(input bit s, input bit smp, input int c);
    exp_t e;
    @(negedge clk);
    start  = s;
    sample = smp;
    cnt    = 3'(c);
    model(s, smp, c);
    e.st = m_mode; e.lk = (m_mode == 2); e.ep = m_ep; e.il = m_il;
    e.sk = m_sticky; e.wr = m_wraps; e.er = m_errs;
    q.push_back(e);
  endtask

  task automatic samples(input int v[]);
    foreach (v[i]) step(1'b0, 1'b1, v[i]);
  endtask

  initial begin : monitor
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        exp_t e;
        e = q.pop_front();
        chk("state", int'(state), e.st);
        chk("locked", int'(locked), e.lk);
        chk("err_pulse", int'(err_pulse), e.ep);
        chk("illegal", int'(illegal), e.il);
        chk("err_sticky", int'(err_sticky), e.sk);
        chk("wraps", int'(wraps), e.wr);
        chk("errs", int'(errs), e.er);
      end
    end
  end

  task automatic settle();
    @(posedge clk);
    #3;
  endtask

  initial begin : driver
    int c;
    bit s, smp;
    int v;
    clr = 1'b1; start = 1'b0; sample = 1'b0; cnt = '0;
    model_reset();
    #2 clr = 1'b0;
    #2;
    chk("rst_state", int'(state), 0);
    chk("rst_outs", int'({locked, err_pulse, illegal, err_sticky}), 0);
    chk("rst_cnts", int'(wraps) + int'(errs), 0);
    @(negedge clk);
    clr = 1'b1;

    // Samples before any start are ignored
    samples('{1, 2, 7});
    // Basic lock and one wrap
    step(1'b1, 1'b0, 0);
    samples('{0, 1, 2, 3, 4, 5, 6, 0, 1});
    settle();
    chk("wraps_first", int'(wraps), 1);
    // Skip error, fault, resync
    samples('{2, 3, 5, 6, 0, 1});
    // Push errs to 3 and relock
    samples('{3, 4, 5, 6, 6, 0, 1, 2});
    settle();
    chk("errs_three", int'(errs), 3);
    chk("relocked", int'(locked), 1);
    // Start beats a simultaneous sample
    step(1'b1, 1'b1, 3);
    settle();
    chk("start_errs", int'(errs), 0);
    chk("start_state", int'(state), 1);
    // Frozen counter at 7
    step(1'b1, 1'b0, 0);
    samples('{7, 7, 7, 7});
    // Error counter saturation
    for (int i = 0; i < 20; i++) samples('{0, 1, 2, 4});
    settle();
    chk("errs_sat", int'(errs), ER_MAX);
    // Wrap counter saturation
    samples('{0, 1, 2});
    for (int i = 0; i < 300; i++) samples('{3, 4, 5, 6, 0, 1, 2});
    settle();
    chk("wraps_sat", int'(wraps), WR_MAX);

    // Random counter stream with glitches, gaps and restarts
    c = 0;
    for (int i = 0; i < 1500; i++) begin
      s   = ($urandom_range(0, 99) < 2);
      smp = 1'($urandom_range(0, 1));
      v   = c;
      if (smp) begin
        if ($urandom_range(0, 15) == 0) v = int'($urandom_range(0, 7));
        c = (c + 1) % MOD;
      end
      step(s, smp, v);
    end

    // Asynchronous clear between edges while locked
    step(1'b1, 1'b0, 0);
    samples('{0, 1, 2, 3});
    @(posedge clk);
    #3 clr = 1'b0;
    #1;
    model_reset();
    chk("clr_state", int'(state), 0);
    chk("clr_locked", int'(locked), 0);
    chk("clr_flags", int'({err_pulse, illegal, err_sticky}), 0);
    chk("clr_cnts", int'(wraps) + int'(errs), 0);
    repeat (3) @(negedge clk);
    clr = 1'b1;
    samples('{4, 5, 6, 7});
    step(1'b1, 1'b0, 0);
    samples('{0, 1, 2, 3});
    step(1'b0, 1'b0, 0);
    repeat (2) @(posedge clk);
    #3;
    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
